bit_serial_alu: RTL and testbench

BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

---
 rtl/bit_serial_alu.sv | 147 ++++++++++++++
 tb/tb_bit_serial_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// ============================================================================
// Module      : bit_serial_alu
// Description : Bit-serial ALU, one operand bit per clock, LSB first.
//               ADD/SUB with carry/overflow flags plus five bitwise logical ops.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             error
);

  localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_a, r_b, r_acc, r_result;
  logic [6:0]           r_op;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_carry, r_carryout, r_overflow, r_zero, r_error;
  logic                 w_onehot, w_last, w_arith, w_bb, w_sum, w_cout, w_bit;
  logic [WIDTH-1:0]     w_acc_next;

  assign w_onehot = (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
  assign w_last   = (r_state == S_SHIFT) && (r_idx == c_last);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = w_onehot ? S_SHIFT : S_DONE;
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // SUB is a + ~b + 1; the +1 comes from the carry seeded at acceptance.
  assign w_arith = r_op[6] | r_op[5];
  assign w_bb    = r_op[5] ? ~r_b[0] : r_b[0];
  assign w_sum   = r_a[0] ^ w_bb ^ r_carry;
  assign w_cout  = (r_a[0] & w_bb) | (r_a[0] & r_carry) | (w_bb & r_carry);

  always_comb begin
    w_bit = r_a[0] | r_b[0];
    case (1'b1)
      r_op[6], r_op[5]: w_bit = w_sum;
      r_op[4]:          w_bit = r_a[0] ^ r_b[0];
      r_op[3]:          w_bit = r_a[0] & r_b[0];
      r_op[2]:          w_bit = ~(r_a[0] & r_b[0]);
      r_op[1]:          w_bit = ~(r_a[0] | r_b[0]);
      default:          w_bit = r_a[0] | r_b[0];
    endcase
  end

  assign w_acc_next = {w_bit, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_acc      <= '0;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_result   <= '0;
          r_carryout <= 1'b0;
          r_overflow <= 1'b0;
          r_zero     <= 1'b0;
          r_error    <= ~w_onehot;
          if (w_onehot) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_idx   <= '0;
            r_carry <= op[5];
            r_acc   <= '0;
          end
        end
        S_SHIFT: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + c_idx_w'(1);
          // Result becomes visible only once the whole word is assembled.
          if (w_last) begin
            r_result   <= w_acc_next;
            r_carryout <= w_arith & w_cout;
            r_overflow <= w_arith & (r_carry ^ w_cout);
            r_zero     <= (w_acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign carryout = r_carryout;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_alu.sv
// ============================================================================
// Module      : tb_bit_serial_alu
// Description : Scoreboard bench for bit_serial_alu (WIDTH=8).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_alu;

  localparam int WIDTH = 8;
  localparam logic [6:0] c_add = 7'b1000000, c_sub = 7'b0100000, c_xor = 7'b0010000,
                         c_and = 7'b0001000, c_nand = 7'b0000100, c_nor = 7'b0000010,
                         c_or = 7'b0000001;

  logic             clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [6:0]       op = '0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             busy, done, carryout, overflow, zero, error;
  logic [WIDTH-1:0] result;

  bit_serial_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carryout(carryout),
    .overflow(overflow), .zero(zero), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       c, v, z, e;
    int         busy_cyc;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, cyc = 0, busy_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done) begin
      if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("carryout", 32'(carryout), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        check("zero", 32'(zero), 32'(e.z));
        check("error", 32'(error), 32'(e.e));
        check("busy_cycles", busy_cnt, e.busy_cyc);
        check("latency", cyc - e.acc, e.lat);
      end
      busy_cnt = 0;
    end
  end

  function automatic exp_t model(input logic [6:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t m;
    logic [8:0] s;
    m = '0;
    m.busy_cyc = WIDTH;
    m.lat = WIDTH;
    if ($countones(o) != 1) begin
      m.e = 1'b1;
      m.busy_cyc = 0;
      m.lat = 0;
      return m;
    end
    s = '0;
    case (1'b1)
      o[6]: begin
        s = {1'b0, x} + {1'b0, y};
        m.res = s[7:0]; m.c = s[8];
        m.v = (x[7] == y[7]) && (s[7] != x[7]);
      end
      o[5]: begin
        s = {1'b0, x} + {1'b0, ~y} + 9'd1;
        m.res = s[7:0]; m.c = s[8];
        m.v = (x[7] != y[7]) && (s[7] != x[7]);
      end
      o[4]: m.res = x ^ y;
      o[3]: m.res = x & y;
      o[2]: m.res = ~(x & y);
      o[1]: m.res = ~(x | y);
      default: m.res = x | y;
    endcase
    m.z = (m.res == 8'h00);
    return m;
  endfunction

  task automatic wait_done();
    int n = 0;
    while (!done && n < WIDTH + 4) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [6:0] o, input logic [7:0] x, input logic [7:0] y, input exp_t e);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic run_hand(input logic [6:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] r, input logic c, input logic v,
                          input logic z, input logic er);
    exp_t e;
    e = '0;
    e.res = r; e.c = c; e.v = v; e.z = z; e.e = er;
    e.busy_cyc = er ? 0 : WIDTH;
    e.lat = er ? 0 : WIDTH;
    issue(o, x, y, e);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int any_busy;
    exp_t e;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, result, carryout, overflow, zero, error}), 32'd0);
    reset_n = 1'b1;

    run_hand(c_add, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    run_hand(c_sub, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run_hand(c_sub, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand(c_xor,  8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand(c_and,  8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand(c_nand, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand(c_nor,  8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand(c_or,   8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start raised during DONE must be dropped, not queued.
    start = 1'b1; op = c_add;
    @(negedge clk);
    start = 1'b0;
    any_busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) any_busy = 1;
    end
    check("start_in_done_ignored", any_busy, 0);
    check("held_result", 32'(result), 32'hFC);
    check("held_zero", 32'(zero), 32'd0);

    run_hand(7'b0000011, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_hand(7'b0000000, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Operand/op changes and a stray start mid-SHIFT must not disturb the sum.
    e = '0;
    e.res = 8'h46; e.busy_cyc = WIDTH; e.lat = WIDTH;
    @(negedge clk);
    op = c_add; a = 8'h12; b = 8'h34; start = 1'b1;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = c_sub; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = c_nor; a = 8'h00; b = 8'h00;
    wait_done();

    // Abort after bit 3 with start held during reset.
    @(negedge clk);
    op = c_add; a = 8'h7F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'({carryout, overflow, zero, error}), 32'd0);
    reset_n = 1'b1; start = 1'b0;
    busy_cnt = 0;
    any_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) any_busy = 1;
    end
    check("no_activity_after_abort", any_busy, 0);

    for (int i = 0; i < 1000; i++) begin
      logic [6:0] o;
      logic [7:0] x, y;
      if ($urandom_range(9) == 0) o = 7'($urandom);
      else o = 7'(1) << $urandom_range(6);
      x = 8'($urandom);
      y = 8'($urandom);
      issue(o, x, y, model(o, x, y));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
